mux_scan_n: RTL

- Parametrised N-channel, W-bit registered multiplexer. Successor to the team's gate-level 2:1 mux.
- Two operating modes:
  - Manual: channel taken from `sel`.
  - Auto-scan: the block steps round-robin through all channels, dwelling a fixed number of cycles on each.
- Used to time-share one datapath or display driver among several sources on the lab boards.
- Output is registered and reports which channel is currently driven.

---
 rtl/mux_scan_n_pkg.sv | 20 ++
 rtl/mux_scan_n_dwell_timer.sv | 39 +++
 rtl/mux_scan_n.sv | 86 ++++++++
 3 files changed

// File: rtl/mux_scan_n_pkg.sv
// Shared definitions for the N-channel registered scan multiplexer.
package mux_scan_n_pkg;

  // Encoding of the mode input.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Operating state, decoded each cycle from mode/hold.
  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_PAUSE  = 2'd2
  } state_e;

  // Width of a channel index for n channels; never less than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_n_dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last cycle of a dwell.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise wrap at the end of a dwell while enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select and
// round-robin auto-scan; reports the driven channel and pulses on changes.
module mux_scan_n
  import mux_scan_n_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DWELL = 4,
  parameter int SELW  = sel_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  din,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic            hold,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] ch,
  output logic            ch_change
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

  state_e          state;
  logic            tick;
  logic [SELW-1:0] ch_q;
  logic [SELW-1:0] ch_d;
  logic [W-1:0]    dout_q;
  logic [W-1:0]    dout_d;
  logic            ch_change_q;
  logic            ch_change_d;

  // State follows mode/hold in the same cycle, so it is a pure decode; the
  // only memory it needs (dwell count, channel) lives in the registers below.
  always_comb begin
    state = ST_MANUAL;
    if (mode == MODE_SCAN) begin
      state = hold ? ST_PAUSE : ST_SCAN;
    end
  end

  // Counter runs only in SCAN and is held at zero in MANUAL, so entering SCAN
  // always starts a full dwell and PAUSE resumes from the held count.
  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .en   (state == ST_SCAN),
    .clr  (state == ST_MANUAL),
    .tick (tick)
  );

  // Next channel, its data and the change flag.
  always_comb begin
    ch_d = ch_q;
    unique case (state)
      ST_MANUAL: if (32'(sel) < 32'(N)) ch_d = sel;
      ST_SCAN:   if (tick) ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
      default:   ch_d = ch_q;
    endcase
    dout_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (ch_d == SELW'(k)) dout_d = din[k*W +: W];
    end
    ch_change_d = (ch_d != ch_q);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q        <= '0;
      dout_q      <= '0;
      ch_change_q <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      dout_q      <= dout_d;
      ch_change_q <= ch_change_d;
    end
  end

  assign dout      = dout_q;
  assign ch        = ch_q;
  assign ch_change = ch_change_q;

endmodule
